dot_product_accumulator: RTL
============================

Name: dot_product_accumulator

Overview:
Downstream stage of the 4-term dot-product unit. Consumes its registered 10-bit results as a valid/ready stream and sums every N_TERMS consecutive results into one wider total. This gives longer vector or matrix-row dot products (e.g. a 16-element product = 4 x 4-term chunks). The total is presented on a valid/ready output and held until it is accepted.

Parameters:
DOT_W, 10, width of each incoming dot-product term (upstream max 4*15*15 = 900).
N_TERMS, 4, number of terms summed per output; legal range >= 1.
ACC_W, DOT_W + $clog2(N_TERMS) (12 at default), accumulator/result width; overflow-free by construction.
CNT_W, $clog2(N_TERMS) with a minimum of 1, width of the term counter.

Ports:
i_clk  input  1  clock, rising edge.
i_rstn  input  1  reset: asynchronous, active-low.
i_clr  input  1  synchronous abort: discards the partial sum and any pending output.
i_dot  input  DOT_W  incoming dot-product term (unsigned).
i_valid  input  1  i_dot is valid this cycle.
o_ready  output  1  block accepts i_dot this cycle (combinational).
o_sum  output  ACC_W  completed sum of N_TERMS terms (unsigned, registered).
o_valid  output  1  o_sum is valid; held until accepted.
i_ready  input  1  downstream accepts o_sum this cycle.
o_count  output  CNT_W  number of terms already accumulated in the current group.

Behaviour:
- Reset (i_rstn low, asynchronous): acc=0, count=0, state=ACCUM, o_sum=0, o_valid=0. The block is ready on the first clock after release.
- Input accept: accept = i_valid & o_ready. Output accept: take = o_valid & i_ready.
- FSM states:
  - ACCUM: no result pending; o_ready=1.
  - HOLD: result pending; o_ready = i_ready, so the next group can start in the same cycle the result is taken.
- i_clr has priority over everything else:
  - o_ready=0 while i_clr=1; an input presented that cycle is dropped.
  - Next edge: acc=0, count=0, o_valid=0, state=ACCUM.
  - o_sum keeps its old value.
- On accept, not the last term (count < N_TERMS-1): acc <= acc + i_dot; count++.
  - If in HOLD, the same edge also completes the take: o_valid<=0, state<=ACCUM.
- On accept, last term (count == N_TERMS-1):
  - o_sum <= acc + i_dot; o_valid<=1; acc<=0; count<=0; state<=HOLD.
  - This also applies in HOLD with take: o_valid stays 1 and o_sum is replaced. No bubble.
- Take without accept: o_valid<=0; state<=ACCUM.
- HOLD with i_ready=0: o_sum and o_valid are frozen; o_ready=0, so upstream stalls.
- Latency: o_sum/o_valid are asserted 1 cycle after the edge that accepts the last term. Sustained throughput is 1 term per cycle when i_ready=1.
- N_TERMS=1: every accepted term goes straight to o_sum; count stays 0.
- Arithmetic: all values zero-extended to ACC_W. There is no saturation; maximum (2^DOT_W - 1) * N_TERMS fits by construction.
- No combinational path from i_dot to any output. o_ready depends only on state, i_clr and i_ready.

Test Plan:
- Reset then terms 900, 900, 900, 900, each with i_valid=1 and i_ready=1 -> o_valid=1 for 1 cycle with o_sum=3600 (0xE10), 1 cycle after the 4th accept; o_count goes 0,1,2,3,0.
- Back-to-back groups {1,2,3,4}, {10,20,30,40}, i_ready=1 continuously -> o_sum=10 then o_sum=100, with no idle cycle on o_ready.
- Group {5,5,5,5} completes while i_ready=0 for 3 cycles -> o_sum=20 and o_valid held; o_ready=0 with next terms stalled; then i_ready=1 with i_valid=1 (term 7) -> take and accept on the same edge; o_valid=0, o_count=1.
- Two terms 100, 200 accepted, then i_clr=1 with i_valid=1 (term 50) -> term 50 dropped, o_count=0; next group {1,1,1,1} -> o_sum=4 (not 304 or 354).
- Assert i_rstn low asynchronously mid-group (o_count=2) and while o_valid=1 -> o_valid, o_sum and o_count go to 0 immediately, without waiting for a clock edge.
- N_TERMS=1 build: terms 7, 8, 9 with i_ready=1 -> o_sum 7, 8, 9 on consecutive cycles with o_valid held high throughout.

Source files
------------

// File: rtl/dot_product_accumulator.sv
// Sums every N_TERMS accepted dot-product terms into one wider total.
// The total is presented on a valid/ready output and held until it is taken.
module dot_product_accumulator #(
    parameter int unsigned DOT_W   = 10,
    parameter int unsigned N_TERMS = 4,
    parameter int unsigned ACC_W   = DOT_W + $clog2(N_TERMS),
    parameter int unsigned CNT_W   = (N_TERMS > 1) ? $clog2(N_TERMS) : 1
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic             i_clr,
    input  logic [DOT_W-1:0] i_dot,
    input  logic             i_valid,
    output logic             o_ready,
    output logic [ACC_W-1:0] o_sum,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [CNT_W-1:0] o_count
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_TERMS - 1);

    typedef enum logic [0:0] {
        ST_ACCUM = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_nxt;
    logic [ACC_W-1:0] sum_nxt;
    logic [ACC_W-1:0] term_ext;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_nxt;
    logic             valid_nxt;
    logic             accept;
    logic             take;
    logic             last;

    assign term_ext = ACC_W'(i_dot);
    assign accept   = i_valid & o_ready;
    assign take     = o_valid & i_ready;
    assign last     = (count == LAST_CNT);
    assign o_count  = count;

    // State register
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state <= ST_ACCUM;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and datapath next values; clear wins over accept and take
    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        count_nxt = count;
        sum_nxt   = o_sum;
        valid_nxt = o_valid;
        if (i_clr) begin
            state_nxt = ST_ACCUM;
            acc_nxt   = '0;
            count_nxt = '0;
            valid_nxt = 1'b0;
        end else if (accept) begin
            if (last) begin
                // A pending result can only be here if it is taken this edge,
                // so the new total replaces it without a bubble.
                state_nxt = ST_HOLD;
                sum_nxt   = acc + term_ext;
                valid_nxt = 1'b1;
                acc_nxt   = '0;
                count_nxt = '0;
            end else begin
                state_nxt = ST_ACCUM;
                acc_nxt   = acc + term_ext;
                count_nxt = count + CNT_W'(1);
                valid_nxt = 1'b0;
            end
        end else if (take) begin
            state_nxt = ST_ACCUM;
            valid_nxt = 1'b0;
        end
    end

    // Ready: in HOLD the next group may start only as the result is taken
    always_comb begin
        o_ready = 1'b0;
        if (!i_clr) begin
            o_ready = (state == ST_HOLD) ? i_ready : 1'b1;
        end
    end

    // Accumulator, counter and registered result
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            acc     <= '0;
            count   <= '0;
            o_sum   <= '0;
            o_valid <= 1'b0;
        end else begin
            acc     <= acc_nxt;
            count   <= count_nxt;
            o_sum   <= sum_nxt;
            o_valid <= valid_nxt;
        end
    end

endmodule
